// File: rtl/ysyx_23060208_dsram_if.sv
// AXI4-Lite-style bus bundle for the data SRAM: AW/W/B write channels and AR/R read channels.
interface ysyx_23060208_dsram_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] dsram_awaddr;
  logic                  dsram_awvalid;
  logic                  dsram_awready;

  logic [DATA_WIDTH-1:0] dsram_wdata;
  logic [2:0]            dsram_wstrb;
  logic                  dsram_wvalid;
  logic                  dsram_wready;

  logic [1:0]            dsram_bresp;
  logic                  dsram_bvalid;
  logic                  dsram_bready;

  logic [DATA_WIDTH-1:0] dsram_araddr;
  logic                  dsram_arvalid;
  logic                  dsram_arready;

  logic [DATA_WIDTH-1:0] dsram_rdata;
  logic [1:0]            dsram_rresp;
  logic                  dsram_rvalid;
  logic                  dsram_rready;

  modport master (
    output dsram_awaddr, dsram_awvalid, input dsram_awready,
    output dsram_wdata, dsram_wstrb, dsram_wvalid, input dsram_wready,
    input  dsram_bresp, dsram_bvalid, output dsram_bready,
    output dsram_araddr, dsram_arvalid, input dsram_arready,
    input  dsram_rdata, dsram_rresp, dsram_rvalid, output dsram_rready
  );

  modport slave (
    input  dsram_awaddr, dsram_awvalid, output dsram_awready,
    input  dsram_wdata, dsram_wstrb, dsram_wvalid, output dsram_wready,
    output dsram_bresp, dsram_bvalid, input dsram_bready,
    input  dsram_araddr, dsram_arvalid, output dsram_arready,
    output dsram_rdata, dsram_rresp, dsram_rvalid, input dsram_rready
  );
endinterface

// File: rtl/ysyx_23060208_dsram.sv
// Data SRAM with independent read/write FSMs and a 2-bit response delay counter.
// Define DSRAM_RAND_DELAY_EN to draw the delay load value from an 8-bit LFSR (0-3 extra cycles).
module ysyx_23060208_dsram #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 12,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_23060208_dsram_if.slave   bus
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned NLANE = DW / 8;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned OFF_W = DEPTH_LOG2 + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] STRB_WORD   = 3'b100;
  localparam logic [2:0] STRB_HALF   = 3'b010;
  localparam logic [2:0] STRB_BYTE   = 3'b001;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

  // True when the byte address falls inside the mapped window.
  function automatic logic in_range(input logic [DW-1:0] addr);
    logic [DW-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> OFF_W) == '0);
  endfunction

  logic [DW-1:0] mem_q [DEPTH];

  logic [1:0] dly_load;

`ifdef DSRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign dly_load = lfsr_q[1:0];
`else
  assign dly_load = 2'd0;
`endif

  // ---------------- read channel ----------------
  r_state_e      r_state_q, r_state_d;
  logic [1:0]    r_cnt_q, r_cnt_d;
  logic [DW-1:0] raddr_q, raddr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;

  logic [DW-1:0] rd_word;
  logic [DW-1:0] rd_shifted;
  logic          rd_ok;

  assign rd_word    = mem_q[raddr_q[OFF_W-1:2]];
  assign rd_shifted = rd_word >> {raddr_q[1:0], 3'b000};
  assign rd_ok      = in_range(raddr_q);

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (bus.dsram_arvalid && arready_q) begin
          raddr_d   = bus.dsram_araddr;
          r_cnt_d   = dly_load;
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 2'd0) begin
          rdata_d   = rd_ok ? rd_shifted : '0;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 2'd1;
        end
      end
      R_RESP: begin
        if (bus.dsram_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 2'd0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // ---------------- write channel ----------------
  w_state_e      w_state_q, w_state_d;
  logic [1:0]    w_cnt_q, w_cnt_d;
  logic [DW-1:0] waddr_q, waddr_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;

  logic             mem_we;
  logic [NLANE-1:0] mem_be;
  logic [DW-1:0]    mem_wdata;
  logic             wr_err;
  logic [2:0]       wstrb;

  assign wstrb     = bus.dsram_wstrb;
  assign mem_wdata = bus.dsram_wdata << {waddr_q[1:0], 3'b000};

  // Size/alignment/range check and lane selection for the pending store.
  always_comb begin
    wr_err = !in_range(waddr_q)
          || !(wstrb inside {STRB_WORD, STRB_HALF, STRB_BYTE})
          || ((wstrb == STRB_WORD) && (waddr_q[1:0] != 2'b00))
          || ((wstrb == STRB_HALF) && waddr_q[0]);
    unique case (wstrb)
      STRB_BYTE: mem_be = NLANE'(1) << waddr_q[1:0];
      STRB_HALF: mem_be = NLANE'(3) << {waddr_q[1], 1'b0};
      STRB_WORD: mem_be = '1;
      default:   mem_be = '0;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    waddr_d   = waddr_q;
    bresp_d   = bresp_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (bus.dsram_awvalid && awready_q) begin
          waddr_d   = bus.dsram_awaddr;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.dsram_wvalid && wready_q) begin
          mem_we    = !wr_err;
          bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
          w_cnt_d   = dly_load;
          wready_d  = 1'b0;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 2'd0) begin
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 2'd1;
        end
      end
      W_RESP: begin
        if (bus.dsram_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 2'd0;
      waddr_q   <= '0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      waddr_q   <= waddr_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Storage is never reset so committed data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NLANE; i++) begin
        if (mem_be[i]) mem_q[waddr_q[OFF_W-1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign bus.dsram_arready = arready_q;
  assign bus.dsram_rdata   = rdata_q;
  assign bus.dsram_rresp   = rresp_q;
  assign bus.dsram_rvalid  = rvalid_q;
  assign bus.dsram_awready = awready_q;
  assign bus.dsram_wready  = wready_q;
  assign bus.dsram_bresp   = bresp_q;
  assign bus.dsram_bvalid  = bvalid_q;

endmodule
